asin_angle_search: RTL

- Inverse of the beam-steering sine lookup. Takes a measured sine magnitude and sign, and returns the nearest integer arrival angle in degrees, in the range -90..+90.
- Typical source: sin(theta) derived from inter-element time-of-arrival delay. The result feeds the display and tracking logic.
- Method: sequential binary search over an internal 91-entry sin(0..90°) ROM, then a nearest-neighbour rounding step.
- Valid/ready handshake on both input and output.

---
 rtl/asin_angle_search.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/asin_angle_search.sv
`default_nettype none
// ============================================================================
// Module   : asin_angle_search
// Brief    : Sine magnitude/sign -> nearest integer angle (-90..90 deg) by a
//            fixed 7-step binary search over a sin(0..90) ROM, then rounding.
// Revision : 1.0
// ============================================================================
module asin_angle_search #(
   parameter int SIN_WIDTH   = 17,
   parameter int ANGLE_WIDTH = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [SIN_WIDTH-1:0]   sin_mag_in,
   input  logic                   sin_sign_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [ANGLE_WIDTH-1:0] angle_out,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int                   c_EW        = SIN_WIDTH + 1;
   localparam logic [SIN_WIDTH-1:0] c_ONE       = SIN_WIDTH'(65536);
   localparam logic [6:0]           c_MAX_DEG   = 7'd90;
   localparam logic [2:0]           c_LAST_ITER = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_ROUND  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [6:0]             r_lo, w_lo_nxt;
   logic [6:0]             r_hi, w_hi_nxt;
   logic [2:0]             r_iter, w_iter_nxt;
   logic [SIN_WIDTH-1:0]   r_mag, w_mag_nxt;
   logic                   r_sign, w_sign_nxt;
   logic [ANGLE_WIDTH-1:0] r_angle, w_angle_nxt;

   logic [6:0]             w_mid;
   logic [c_EW-1:0]        w_mag_ext, w_rom_mid, w_rom_lo, w_rom_up;
   logic [c_EW-1:0]        w_dist_up, w_dist_lo;
   logic [6:0]             w_k;
   logic [ANGLE_WIDTH-1:0] w_k_ext;

   // floor(sin(k deg) * 65536); index 91 and above read as zero
   function automatic logic [16:0] f_sin_rom(input logic [6:0] idx);
      logic [16:0] v;
      case (idx)
         7'd0:  v = 17'd0;     7'd1:  v = 17'd1143;  7'd2:  v = 17'd2287;  7'd3:  v = 17'd3429;  7'd4:  v = 17'd4571;
         7'd5:  v = 17'd5711;  7'd6:  v = 17'd6850;  7'd7:  v = 17'd7986;  7'd8:  v = 17'd9120;  7'd9:  v = 17'd10252;
         7'd10: v = 17'd11380; 7'd11: v = 17'd12504; 7'd12: v = 17'd13625; 7'd13: v = 17'd14742; 7'd14: v = 17'd15854;
         7'd15: v = 17'd16961; 7'd16: v = 17'd18064; 7'd17: v = 17'd19160; 7'd18: v = 17'd20251; 7'd19: v = 17'd21336;
         7'd20: v = 17'd22414; 7'd21: v = 17'd23486; 7'd22: v = 17'd24550; 7'd23: v = 17'd25606; 7'd24: v = 17'd26655;
         7'd25: v = 17'd27696; 7'd26: v = 17'd28729; 7'd27: v = 17'd29752; 7'd28: v = 17'd30767; 7'd29: v = 17'd31772;
         7'd30: v = 17'd32768; 7'd31: v = 17'd33753; 7'd32: v = 17'd34728; 7'd33: v = 17'd35693; 7'd34: v = 17'd36647;
         7'd35: v = 17'd37589; 7'd36: v = 17'd38521; 7'd37: v = 17'd39440; 7'd38: v = 17'd40347; 7'd39: v = 17'd41243;
         7'd40: v = 17'd42125; 7'd41: v = 17'd42995; 7'd42: v = 17'd43852; 7'd43: v = 17'd44695; 7'd44: v = 17'd45525;
         7'd45: v = 17'd46340; 7'd46: v = 17'd47142; 7'd47: v = 17'd47929; 7'd48: v = 17'd48702; 7'd49: v = 17'd49460;
         7'd50: v = 17'd50203; 7'd51: v = 17'd50931; 7'd52: v = 17'd51643; 7'd53: v = 17'd52339; 7'd54: v = 17'd53019;
         7'd55: v = 17'd53683; 7'd56: v = 17'd54331; 7'd57: v = 17'd54963; 7'd58: v = 17'd55577; 7'd59: v = 17'd56175;
         7'd60: v = 17'd56755; 7'd61: v = 17'd57319; 7'd62: v = 17'd57864; 7'd63: v = 17'd58393; 7'd64: v = 17'd58903;
         7'd65: v = 17'd59395; 7'd66: v = 17'd59870; 7'd67: v = 17'd60326; 7'd68: v = 17'd60763; 7'd69: v = 17'd61183;
         7'd70: v = 17'd61583; 7'd71: v = 17'd61965; 7'd72: v = 17'd62328; 7'd73: v = 17'd62672; 7'd74: v = 17'd62997;
         7'd75: v = 17'd63302; 7'd76: v = 17'd63589; 7'd77: v = 17'd63856; 7'd78: v = 17'd64103; 7'd79: v = 17'd64331;
         7'd80: v = 17'd64540; 7'd81: v = 17'd64729; 7'd82: v = 17'd64898; 7'd83: v = 17'd65047; 7'd84: v = 17'd65176;
         7'd85: v = 17'd65286; 7'd86: v = 17'd65376; 7'd87: v = 17'd65446; 7'd88: v = 17'd65496; 7'd89: v = 17'd65526;
         7'd90: v = 17'd65536;
         default: v = 17'd0;
      endcase
      return v;
   endfunction

   assign w_mid     = 7'(({1'b0, r_lo} + {1'b0, r_hi} + 8'd1) >> 1);
   assign w_mag_ext = c_EW'(r_mag);
   assign w_rom_mid = c_EW'(f_sin_rom(w_mid));
   assign w_rom_lo  = c_EW'(f_sin_rom(r_lo));
   assign w_rom_up  = c_EW'(f_sin_rom(r_lo + 7'd1));

   // Search leaves rom[lo] <= mag < rom[lo+1], so both distances are non-negative
   assign w_dist_up = w_rom_up - w_mag_ext;
   assign w_dist_lo = w_mag_ext - w_rom_lo;
   assign w_k       = ((r_lo < c_MAX_DEG) && (w_dist_up < w_dist_lo)) ? (r_lo + 7'd1) : r_lo;
   assign w_k_ext   = ANGLE_WIDTH'(w_k);

   always_comb begin
      w_state_nxt = r_state;
      w_lo_nxt    = r_lo;
      w_hi_nxt    = r_hi;
      w_iter_nxt  = r_iter;
      w_mag_nxt   = r_mag;
      w_sign_nxt  = r_sign;
      w_angle_nxt = r_angle;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_mag_nxt   = (sin_mag_in > c_ONE) ? c_ONE : sin_mag_in;
               w_sign_nxt  = sin_sign_in;
               w_lo_nxt    = 7'd0;
               w_hi_nxt    = c_MAX_DEG;
               w_iter_nxt  = 3'd0;
               w_state_nxt = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (r_lo != r_hi) begin
               if (w_rom_mid <= w_mag_ext) w_lo_nxt = w_mid;
               else                        w_hi_nxt = w_mid - 7'd1;
            end
            w_iter_nxt = r_iter + 3'd1;
            if (r_iter == c_LAST_ITER) w_state_nxt = S_ROUND;
         end
         S_ROUND: begin
            w_angle_nxt = r_sign ? (-w_k_ext) : w_k_ext;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_lo    <= 7'd0;
         r_hi    <= 7'd0;
         r_iter  <= 3'd0;
         r_mag   <= '0;
         r_sign  <= 1'b0;
         r_angle <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lo    <= w_lo_nxt;
         r_hi    <= w_hi_nxt;
         r_iter  <= w_iter_nxt;
         r_mag   <= w_mag_nxt;
         r_sign  <= w_sign_nxt;
         r_angle <= w_angle_nxt;
      end
   end

   assign angle_out = r_angle;

endmodule
`default_nettype wire
